sm_regdump_uart: RTL

Debug register dumper on the CPU's debug read port. On a start pulse it walks `regAddr` from 0 to 31 and captures each `regData` word; address 0 yields the PC. It sends each word over a UART TX line as one ASCII text line. It lets a board with only a serial pin show the full register file without a hex display.

---
 rtl/sm_regdump_uart_if.sv | 28 ++
 rtl/sm_regdump_uart.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sm_regdump_uart_if.sv
// Debug-port and UART signal bundle for the register dumper.
// The master side is the dumper itself; the slave side is the CPU/board environment.
interface sm_regdump_uart_if;
    logic        start;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        tx;
    logic        busy;
    logic        done;

    modport master (
        input  start,
        input  regData,
        output regAddr,
        output tx,
        output busy,
        output done
    );

    modport slave (
        output start,
        output regData,
        input  regAddr,
        input  tx,
        input  busy,
        input  done
    );
endinterface

// File: rtl/sm_regdump_uart.sv
// Register dumper: walks the CPU debug read port over addresses 0..31 and
// prints each word as "AA:DDDDDDDD\r\n" on a UART TX line (8N1, LSB first).
// Every output is taken straight from a flop so the TX line never glitches.
module sm_regdump_uart #(
    parameter int BAUD_DIV = 434
) (
    input  logic               clk,
    input  logic               rst_n,
    sm_regdump_uart_if.master  bus
);
    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETADDR = 3'd1,
        S_CAPTURE = 3'd2,
        S_SEND    = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [4:0]    addr_q, addr_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [3:0]    byte_q, byte_d;     // 0..12 within a text line
    logic [3:0]    bit_q, bit_d;       // 0 start, 1..8 data, 9 stop
    logic [CW-1:0] baud_q, baud_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          line_end_s;

    // Uppercase ASCII hex digit for one nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            hex_ascii = 8'h30 + {4'h0, n};
        end else begin
            hex_ascii = 8'h37 + {4'h0, n};
        end
    endfunction

    // Character at position idx of the line for address a and word w.
    function automatic logic [7:0] line_byte(input logic [3:0] idx,
                                             input logic [4:0] a,
                                             input logic [31:0] w);
        logic [3:0] nib;
        nib = 4'(w >> (5'd4 * 5'(4'd10 - idx)));
        case (idx)
            4'd0:    line_byte = hex_ascii({3'b000, a[4]});
            4'd1:    line_byte = hex_ascii(a[3:0]);
            4'd2:    line_byte = 8'h3A;
            4'd11:   line_byte = 8'h0D;
            4'd12:   line_byte = 8'h0A;
            default: begin
                if ((idx >= 4'd3) && (idx <= 4'd10)) begin
                    line_byte = hex_ascii(nib);
                end else begin
                    line_byte = 8'hFF;
                end
            end
        endcase
    endfunction

    // Serial level for frame position bit_idx of byte b.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] bit_idx);
        if (bit_idx == 4'd0) begin
            frame_bit = 1'b0;
        end else if (bit_idx <= 4'd8) begin
            frame_bit = b[3'(bit_idx - 4'd1)];
        end else begin
            frame_bit = 1'b1;
        end
    endfunction

    assign line_end_s = (state_q == S_SEND) && (baud_q == BAUD_LAST) &&
                        (bit_q == 4'd9) && (byte_q == 4'd12);

    // State register and all datapath/output flops; reset forces TX idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= 5'd0;
            shadow_q <= 32'd0;
            byte_q   <= 4'd0;
            bit_q    <= 4'd0;
            baud_q   <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            shadow_q <= shadow_d;
            byte_q   <= byte_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: start is only honoured from IDLE, so DONE swallows it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_SETADDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETADDR: state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_SEND;
            S_SEND: begin
                if (line_end_s) begin
                    state_d = (addr_q == 5'd31) ? S_DONE : S_SETADDR;
                end else begin
                    state_d = S_SEND;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values; tx is computed from the
    // counters' next values so the flop shows the bit of the coming cycle.
    always_comb begin
        addr_d   = addr_q;
        shadow_d = shadow_q;
        byte_d   = byte_q;
        bit_d    = bit_q;
        baud_d   = baud_q;
        case (state_q)
            S_IDLE: addr_d = 5'd0;
            S_CAPTURE: begin
                shadow_d = bus.regData;
                byte_d   = 4'd0;
                bit_d    = 4'd0;
                baud_d   = '0;
            end
            S_SEND: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 4'd9) begin
                        bit_d  = 4'd0;
                        byte_d = (byte_q == 4'd12) ? 4'd0 : (byte_q + 4'd1);
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
                if (line_end_s) begin
                    addr_d = (addr_q == 5'd31) ? 5'd0 : (addr_q + 5'd1);
                end else begin
                    addr_d = addr_q;
                end
            end
            default: addr_d = addr_q;
        endcase

        busy_d = (state_d == S_SETADDR) || (state_d == S_CAPTURE) || (state_d == S_SEND);
        done_d = (state_d == S_DONE);
        if (state_d == S_SEND) begin
            tx_d = frame_bit(line_byte(byte_d, addr_q, shadow_d), bit_d);
        end else begin
            tx_d = 1'b1;
        end
    end

    assign bus.regAddr = addr_q;
    assign bus.tx      = tx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule
